onehot_rr_arbiter: RTL and testbench

Round-robin arbiter for eight request lines that drives the one-hot vector consumed by the octal-to-binary encoder stage. It owns the sequential decision of who is served: it picks exactly one requester with rotating priority, holds that one-hot grant stable until the client signals completion, aborts, or times out, then advances priority. Its `grant` output is always zero or one-hot, never multi-hot, so the downstream encoder always sees a legal input.

---
 rtl/onehot_rr_arbiter_pkg.sv | 10 +
 rtl/onehot_rr_arbiter_rr_pick.sv | 27 ++
 rtl/onehot_rr_arbiter.sv | 88 ++++++++
 tb/tb_onehot_rr_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared constants and FSM encoding for the eight-way round-robin arbiter.
package onehot_rr_arbiter_pkg;
   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;
endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational rotating-priority pick: first set request at or after ptr, wrapping.
module rr_pick
   import onehot_rr_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx
);
   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic [IDX_W-1:0]     w_ffs;

   // Rotate so ptr lands at bit 0, then fixed priority from bit 0 upward.
   assign w_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot = w_dbl[NUM_REQ-1:0];

   always_comb begin
      w_ffs = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (w_rot[i]) w_ffs = IDX_W'(i);
      end
   end

   assign o_idx    = w_ffs + i_ptr;
   assign o_onehot = (|i_req) ? (NUM_REQ'(1) << o_idx) : '0;
endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: holds a registered one-hot grant until done, abort or hold timeout.
module onehot_rr_arbiter
   import onehot_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_done,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_grant_valid,
   output logic               o_timeout
);
   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]   r_gidx, w_gidx_nxt;
   logic [7:0]         r_hold_cnt, w_hold_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
   logic               r_grant_valid;
   logic               r_timeout, w_timeout_nxt;
   logic [NUM_REQ-1:0] w_pick_oh;
   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_hold_last;

   rr_pick u_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx)
   );

   assign w_hold_last = (r_hold_cnt == 8'(MAX_HOLD - 1));

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_gidx_nxt    = r_gidx;
      w_hold_nxt    = r_hold_cnt;
      w_grant_nxt   = r_grant;
      w_timeout_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|i_req) begin
               w_grant_nxt = w_pick_oh;
               w_gidx_nxt  = w_pick_idx;
               w_hold_nxt  = '0;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (r_hold_cnt != 8'hFF) w_hold_nxt = r_hold_cnt + 8'd1;
            // done outranks abort, abort outranks timeout
            if (i_done || !i_req[r_gidx] || w_hold_last) begin
               w_grant_nxt   = '0;
               w_ptr_nxt     = r_gidx + 1'b1;
               w_state_nxt   = ST_IDLE;
               w_timeout_nxt = !i_done && i_req[r_gidx];
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_gidx        <= '0;
         r_hold_cnt    <= '0;
         r_grant       <= '0;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_gidx        <= w_gidx_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_grant       <= w_grant_nxt;
         r_grant_valid <= |w_grant_nxt;
         r_timeout     <= w_timeout_nxt;
      end
   end

   assign o_grant       = r_grant;
   assign o_grant_valid = r_grant_valid;
   assign o_timeout     = r_timeout;
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench: directed cases plus random traffic against a cycle-count reference model.
module tb_onehot_rr_arbiter;
   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0;
   logic       done = 1'b0;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   bit         m_busy = 0;
   int         m_g = 0;
   int         m_ptr = 0;
   int         m_cnt = 0;
   logic [7:0] m_grant = '0;
   logic       m_to = 1'b0;

   onehot_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req         (req),
      .i_done        (done),
      .o_grant       (grant),
      .o_grant_valid (grant_valid),
      .o_timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit rel, to;
      if (rst) begin
         m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_grant = '0; m_to = 1'b0;
      end else if (!m_busy) begin
         m_to = 1'b0;
         if (req != 0) begin
            for (int k = 7; k >= 0; k--)
               if (req[(m_ptr + k) % 8]) m_g = (m_ptr + k) % 8;
            m_busy  = 1;
            m_cnt   = 1;
            m_grant = 8'(1 << m_g);
         end
      end else begin
         rel = 0; to = 0;
         if (done) rel = 1;
         else if (!req[m_g]) rel = 1;
         else if (m_cnt == MH) begin rel = 1; to = 1; end
         if (rel) begin
            m_busy = 0; m_ptr = (m_g + 1) % 8; m_grant = '0;
         end else begin
            m_cnt++;
         end
         m_to = to;
      end
   endtask

   // apply inputs, take one edge, check all outputs against the model
   task automatic step(input logic r, input logic [7:0] q, input logic d);
      rst = r; req = q; done = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("grant", grant, m_grant);
      chk("grant_valid", 8'(grant_valid), 8'(m_grant != 0));
      chk("timeout", 8'(timeout), 8'(m_to));
   endtask

   logic [7:0] rot_exp [16];
   logic [7:0] rq;
   logic       rr, rd;

   initial begin
      rot_exp = '{8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08, 8'h00, 8'h10,
                  8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h80, 8'h00, 8'h01};

      // reset, then first grant
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 8'hFF, 1'b0);
         chk("rst_grant", grant, 8'h00);
         chk("rst_timeout", 8'(timeout), 8'h00);
      end
      step(1'b0, 8'hFF, 1'b0);
      chk("first_grant", grant, 8'h01);

      // rotation with done tied high
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'hFF, 1'b1);
         chk("rotate", grant, rot_exp[i]);
      end
      step(1'b0, 8'hFF, 1'b1);
      chk("rotate_rel", grant, 8'h00);

      // serve 1 so ptr=2, then skip to 7 and wrap to 0
      step(1'b0, 8'h02, 1'b0);
      chk("serve1", grant, 8'h02);
      step(1'b0, 8'h02, 1'b1);
      step(1'b0, 8'h81, 1'b0);
      chk("skip_to7", grant, 8'h80);
      step(1'b0, 8'h81, 1'b1);
      chk("skip_rel", grant, 8'h00);
      step(1'b0, 8'h81, 1'b0);
      chk("wrap_to0", grant, 8'h01);
      step(1'b0, 8'h81, 1'b1);

      // abort on req drop, next pick starts at 3
      step(1'b0, 8'h04, 1'b0);
      chk("abort_grant", grant, 8'h04);
      step(1'b0, 8'h00, 1'b0);
      chk("abort_rel", grant, 8'h00);
      chk("abort_noto", 8'(timeout), 8'h00);
      step(1'b0, 8'hFF, 1'b0);
      chk("after_abort", grant, 8'h08);
      step(1'b0, 8'hFF, 1'b1);

      // forced release after MAX_HOLD cycles
      for (int i = 0; i < MH; i++) begin
         step(1'b0, 8'h10, 1'b0);
         chk("hold", grant, 8'h10);
      end
      step(1'b0, 8'h10, 1'b0);
      chk("to_rel", grant, 8'h00);
      chk("to_pulse", 8'(timeout), 8'h01);
      // again, but done on the last held cycle wins over timeout
      for (int i = 0; i < MH; i++) begin
         step(1'b0, 8'h10, 1'b0);
         chk("hold2", grant, 8'h10);
         chk("hold2_noto", 8'(timeout), 8'h00);
      end
      step(1'b0, 8'h10, 1'b1);
      chk("done_rel", grant, 8'h00);
      chk("done_noto", 8'(timeout), 8'h00);

      // mid-grant reset clears ptr
      step(1'b0, 8'h20, 1'b0);
      chk("pre_rst", grant, 8'h20);
      step(1'b1, 8'h21, 1'b0);
      chk("mid_rst", grant, 8'h00);
      step(1'b0, 8'h21, 1'b0);
      chk("post_rst", grant, 8'h01);

      // random traffic against the model
      rq = 8'hFF;
      for (int i = 0; i < 4000; i++) begin
         rr = ($urandom_range(0, 99) == 0);
         case ($urandom_range(0, 3))
            0: rq = 8'($urandom);
            1: rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
            2: rq = 8'hFF;
            default: ;
         endcase
         rd = ($urandom_range(0, 4) == 0);
         step(rr, rq, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
